game_move_ctrl: RTL and testbench

Move sequencer for the 4x4 2048 game board. It owns the board register and the score register, and turns debounced direction buttons into slide requests to the external slide datapath (one slide unit per direction, muxed outside this block). After a slide it commits the result, spawns a new tile using a pseudo-random scan, and evaluates win and game-over. It sits between the input conditioning logic and the VGA/board renderer.

---
 rtl/game_move_ctrl_pkg.sv | 32 +++
 rtl/game_move_ctrl_if.sv | 25 ++
 rtl/game_move_ctrl_tile_spawner.sv | 49 ++++
 rtl/game_move_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_game_move_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_move_ctrl_pkg.sv
// Shared types and constants for the 2048 move sequencer.
// WIN_HALT_EN adds the terminal WIN state to the controller state set.
package game_pkg;

   typedef logic [15:0][3:0] board_t;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

`ifdef WIN_HALT_EN
   typedef enum logic [2:0] {
      INIT, SPAWN, CHECK, WAIT_IN, SLIDE, COMMIT, OVER, WIN
   } ctrl_state_t;
`else
   typedef enum logic [2:0] {
      INIT, SPAWN, CHECK, WAIT_IN, SLIDE, COMMIT, OVER
   } ctrl_state_t;
`endif

   localparam logic [3:0]  WIN_EXP   = 4'd11;
   // Fibonacci taps 16,14,13,11 mapped onto bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/game_move_ctrl_if.sv
// Slide request/acknowledge channel between the move sequencer and the
// external slide datapath.
interface game_move_ctrl_if #(
   parameter int unsigned SCORE_W = 13
);
   import game_pkg::*;

   logic               slide_req;
   logic [1:0]         slide_dir;
   board_t             board_to_slide;
   logic               slide_ack;
   board_t             slide_board;
   logic [SCORE_W-1:0] slide_points;

   modport master (
      output slide_req, slide_dir, board_to_slide,
      input  slide_ack, slide_board, slide_points
   );

   modport slave (
      input  slide_req, slide_dir, board_to_slide,
      output slide_ack, slide_board, slide_points
   );

endinterface

// File: rtl/game_move_ctrl_tile_spawner.sv
// Free-running LFSR plus the wrapping empty-cell scan used to drop a new tile.
// start_i marks the first scan cycle; the index is then taken from the LFSR.
module tile_spawner
   import game_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       active_i,
   input  board_t     board_i,
   output logic       done_o,
   output logic       wrote_o,
   output logic [3:0] wr_idx_o,
   output logic [3:0] wr_val_o
);

   logic [15:0] lfsr_q;
   logic [3:0]  idx_q, cnt_q;
   logic [3:0]  idx_cur, cnt_cur;
   logic        empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
         idx_q  <= '0;
         cnt_q  <= '0;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
         if (active_i) begin
            idx_q <= idx_cur + 4'd1;
            cnt_q <= cnt_cur + 4'd1;
         end
      end
   end

   always_comb begin
      idx_cur  = start_i ? lfsr_q[3:0] : idx_q;
      cnt_cur  = start_i ? '0 : cnt_q;
      empty    = (board_i[idx_cur] == 4'd0);
      wrote_o  = active_i && empty;
      // sixteenth probe ends the spawn even when the board is full
      done_o   = active_i && (empty || (cnt_cur == 4'd15));
      wr_idx_o = idx_cur;
      wr_val_o = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
   end

endmodule

// File: rtl/game_move_ctrl.sv
// 2048 move sequencer: owns board and score, issues slide requests, spawns
// tiles and flags win/game-over. Define WIN_HALT_EN to stop play on 2048.
module game_move_ctrl
   import game_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned SCORE_W   = 13
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               new_game,
   game_move_ctrl_if.master   slide_if,
   output board_t             board_out,
   output logic [SCORE_W-1:0] score,
   output logic               ready,
   output logic               game_over,
   output logic               game_won
);

   ctrl_state_t        state_q, state_d;
   board_t             board_q, sb_q;
   logic [SCORE_W-1:0] score_q, pts_q, score_sat;
   logic [SCORE_W:0]   score_sum;
   logic [1:0]         spawn_cnt_q;
   logic               start_q, start_d;
   logic               slide_req_q, slide_req_d;
   logic               ready_q, ready_d;
   logic               over_q, over_d;
   logic               won_q, won_d;
   dir_t               dir_q, dir_d;
   logic [3:0]         btn_q, btn_now, rise;
   logic               press, noop;
   logic               chk_won, chk_over, has_zero, has_pair;
   logic               sp_done, sp_wrote;
   logic [3:0]         sp_idx, sp_val;

   tile_spawner #(.LFSR_SEED(LFSR_SEED)) u_spawner (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_q),
      .active_i (state_q == SPAWN),
      .board_i  (board_q),
      .done_o   (sp_done),
      .wrote_o  (sp_wrote),
      .wr_idx_o (sp_idx),
      .wr_val_o (sp_val)
   );

   assign btn_now   = {btn_up, btn_down, btn_left, btn_right};
   assign rise      = btn_now & ~btn_q;
   assign press     = |rise;
   assign noop      = (sb_q == board_q);
   assign score_sum = {1'b0, score_q} + {1'b0, pts_q};
   assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

   always_comb begin
      chk_won  = 1'b0;
      has_zero = 1'b0;
      has_pair = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (board_q[i] == WIN_EXP) chk_won = 1'b1;
         if (board_q[i] == 4'd0) has_zero = 1'b1;
         if ((i % 4 != 3) && (board_q[i] == board_q[i+1])) has_pair = 1'b1;
         if ((i < 12) && (board_q[i] == board_q[i+4])) has_pair = 1'b1;
      end
      chk_over = !has_zero && !has_pair;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    state_d = SPAWN;
         SPAWN:   if (sp_done && spawn_cnt_q == 2'd1) state_d = CHECK;
`ifdef WIN_HALT_EN
         CHECK:   state_d = chk_won ? WIN : (chk_over ? OVER : WAIT_IN);
         WIN:     state_d = WIN;
`else
         CHECK:   state_d = chk_over ? OVER : WAIT_IN;
`endif
         WAIT_IN: if (press) state_d = SLIDE;
         SLIDE:   if (slide_if.slide_ack) state_d = COMMIT;
         COMMIT:  state_d = noop ? WAIT_IN : SPAWN;
         OVER:    state_d = OVER;
         default: state_d = INIT;
      endcase
      if (new_game) state_d = INIT;
   end

   always_comb begin
      slide_req_d = (state_d == SLIDE);
      ready_d     = (state_d == WAIT_IN);
      start_d     = (state_d == SPAWN) && ((state_q != SPAWN) || sp_done);
      dir_d       = dir_q;
      if (state_q == WAIT_IN && press) begin
         if      (rise[3]) dir_d = UP;
         else if (rise[2]) dir_d = DOWN;
         else if (rise[1]) dir_d = LEFT;
         else              dir_d = RIGHT;
      end
      won_d  = won_q  || (state_q == CHECK && chk_won);
`ifdef WIN_HALT_EN
      over_d = over_q || (state_q == CHECK && chk_over && !chk_won);
`else
      over_d = over_q || (state_q == CHECK && chk_over);
`endif
      if (state_d == INIT) begin
         won_d  = 1'b0;
         over_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slide_req_q <= 1'b0;
         ready_q     <= 1'b0;
         start_q     <= 1'b0;
         dir_q       <= UP;
         won_q       <= 1'b0;
         over_q      <= 1'b0;
         btn_q       <= '0;
      end else begin
         slide_req_q <= slide_req_d;
         ready_q     <= ready_d;
         start_q     <= start_d;
         dir_q       <= dir_d;
         won_q       <= won_d;
         over_q      <= over_d;
         btn_q       <= btn_now;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         board_q     <= '0;
         score_q     <= '0;
         spawn_cnt_q <= '0;
         sb_q        <= '0;
         pts_q       <= '0;
      end else begin
         case (state_q)
            INIT: begin
               board_q     <= '0;
               score_q     <= '0;
               spawn_cnt_q <= 2'd2;
            end
            SPAWN: begin
               if (sp_wrote) board_q[sp_idx] <= sp_val;
               if (sp_done)  spawn_cnt_q <= spawn_cnt_q - 2'd1;
            end
            SLIDE: begin
               if (slide_if.slide_ack) begin
                  sb_q  <= slide_if.slide_board;
                  pts_q <= slide_if.slide_points;
               end
            end
            COMMIT: begin
               if (!noop) begin
                  board_q     <= sb_q;
                  score_q     <= score_sat;
                  spawn_cnt_q <= 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign slide_if.slide_req      = slide_req_q;
   assign slide_if.slide_dir      = dir_q;
   assign slide_if.board_to_slide = board_q;
   assign board_out               = board_q;
   assign score                   = score_q;
   assign ready                   = ready_q;
   assign game_over               = over_q;
   assign game_won                = won_q;

endmodule

// File: tb/tb_game_move_ctrl.sv
// Directed bench for game_move_ctrl; the bench plays the slide datapath.
// Honours WIN_HALT_EN to pick the expected win behaviour.
module tb_game_move_ctrl;
   import game_pkg::*;

   localparam int unsigned SW = 13;

   localparam board_t B1 = 64'h0000_3000_2000_1000;
   localparam board_t F1 = 64'h4321_4321_4321_4321;
   localparam board_t F2 = 64'h5555_5555_5555_5555;
   localparam board_t W  = 64'h0000_0000_0000_003B;
   localparam board_t G  = 64'hA987_6543_9876_5430;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0, ng = 1'b0;
   board_t          board_out;
   logic [SW-1:0]   score;
   logic            ready, game_over, game_won;
   int              n_tests = 0;
   int              n_fail  = 0;

   game_move_ctrl_if #(.SCORE_W(SW)) sif ();

   always #5 clk = ~clk;

   game_move_ctrl #(.LFSR_SEED(16'hACE1), .SCORE_W(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_up    (bu),
      .btn_down  (bd),
      .btn_left  (bl),
      .btn_right (br),
      .new_game  (ng),
      .slide_if  (sif),
      .board_out (board_out),
      .score     (score),
      .ready     (ready),
      .game_over (game_over),
      .game_won  (game_won)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nz(input board_t b);
      int n = 0;
      for (int i = 0; i < 16; i++) if (b[i] != 4'd0) n++;
      return n;
   endfunction

   function automatic bit small_tiles(input board_t b);
      for (int i = 0; i < 16; i++) if (b[i] > 4'd2) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_ready(input int max, input string tag, output int cycles);
      cycles = 0;
      while (!ready && cycles < max) begin
         tick();
         cycles++;
      end
      check_val({tag, "_ready"}, ready, 1);
   endtask

   task automatic fresh_board(input string tag);
      check_val({tag, "_score"}, score, 0);
      check_val({tag, "_tiles"}, nz(board_out), 2);
      check_val({tag, "_vals"}, small_tiles(board_out), 1);
   endtask

   // btns = {up, down, left, right}; ack arrives in the first SLIDE cycle
   task automatic do_slide(input logic [3:0] btns, input logic [1:0] exp_dir,
                           input board_t nb, input logic [SW-1:0] pts,
                           input bit hold, input string tag);
      {bu, bd, bl, br} = btns;
      tick();
      check_val({tag, "_req"}, sif.slide_req, 1);
      check_val({tag, "_dir"}, sif.slide_dir, exp_dir);
      sif.slide_ack    = 1'b1;
      sif.slide_board  = nb;
      sif.slide_points = pts;
      tick();
      sif.slide_ack = 1'b0;
      if (!hold) {bu, bd, bl, br} = 4'b0000;
   endtask

   initial begin
      int cyc;
      int extra;
      bit quiet;
      sif.slide_ack    = 1'b0;
      sif.slide_board  = '0;
      sif.slide_points = '0;

      // reset state
      tick();
      tick();
      check_val("rst_board", board_out, 0);
      check_val("rst_score", score, 0);
      check_val("rst_flags", {sif.slide_req, ready, game_over, game_won}, 0);
      rst_n = 1'b1;
      wait_ready(40, "init", cyc);
      check_val("init_latency_le34", (cyc <= 34), 1);
      fresh_board("init");

      // left move with points: 3 preserved cells plus one spawned tile
      do_slide(4'b0010, 2'd2, B1, 13'd3, 1'b0, "left");
      wait_ready(25, "left", cyc);
      check_val("left_score", score, 3);
      check_val("left_tiles", nz(board_out), 4);
      check_val("left_keep", {board_out[3], board_out[7], board_out[11]}, 12'h123);
      extra = 0;
      for (int i = 0; i < 16; i++)
         if (i != 3 && i != 7 && i != 11 && (board_out[i] == 4'd1 || board_out[i] == 4'd2)) extra++;
      check_val("left_spawn", extra, 1);

      // up+right together, held; full board so no spawn lands
      do_slide(4'b1001, 2'd0, F1, 13'd10, 1'b1, "upright");
      wait_ready(25, "upright", cyc);
      check_val("upright_board", board_out, F1);
      check_val("upright_score", score, 13);
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (sif.slide_req || !ready) quiet = 1'b0;
      end
      check_val("held_no_repeat", quiet, 1);
      {bu, bd, bl, br} = 4'b0000;
      tick();

      // no-op move: ready returns at ack+2
      bd = 1'b1;
      tick();
      check_val("noop_req", sif.slide_req, 1);
      check_val("noop_dir", sif.slide_dir, 1);
      check_val("noop_bts", sif.board_to_slide, F1);
      sif.slide_ack    = 1'b1;
      sif.slide_board  = F1;
      sif.slide_points = 13'd5;
      tick();
      sif.slide_ack = 1'b0;
      bd = 1'b0;
      check_val("noop_ack1_ready", ready, 0);
      tick();
      check_val("noop_ack2_ready", ready, 1);
      check_val("noop_board", board_out, F1);
      check_val("noop_score", score, 13);

      // saturation
      do_slide(4'b0001, 2'd3, F2, 13'd8000, 1'b0, "big");
      wait_ready(25, "big", cyc);
      check_val("big_score", score, 8013);
      do_slide(4'b0010, 2'd2, F1, 13'd500, 1'b0, "sat");
      wait_ready(25, "sat", cyc);
      check_val("sat_score", score, 8191);

      // asynchronous reset mid-slide
      bu = 1'b1;
      tick();
      check_val("arst_req_before", sif.slide_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_req_drop", sif.slide_req, 0);
      bu = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_ready(40, "arst", cyc);
      fresh_board("arst");

      // 2048 tile
      do_slide(4'b1000, 2'd0, W, 13'd0, 1'b0, "win");
`ifdef WIN_HALT_EN
      for (int i = 0; i < 25; i++) tick();
      check_val("win_ready", ready, 0);
`else
      wait_ready(25, "win", cyc);
`endif
      check_val("win_won", game_won, 1);
      check_val("win_over", game_over, 0);

      ng = 1'b1;
      tick();
      ng = 1'b0;
      wait_ready(40, "ng1", cyc);
      check_val("ng1_won", game_won, 0);
      fresh_board("ng1");

      // dead board: the lone hole takes a 1 or 2, no merges left
      do_slide(4'b0100, 2'd1, G, 13'd4, 1'b0, "over");
      for (int i = 0; i < 25; i++) tick();
      check_val("over_flag", game_over, 1);
      check_val("over_ready", ready, 0);
      check_val("over_tiles", nz(board_out), 16);
      check_val("over_cell0", (board_out[0] == 4'd1 || board_out[0] == 4'd2), 1);
      check_val("over_score", score, 4);
      bl = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (sif.slide_req) quiet = 1'b0;
      end
      bl = 1'b0;
      check_val("over_ignores_btn", quiet, 1);
      ng = 1'b1;
      tick();
      ng = 1'b0;
      wait_ready(40, "ng2", cyc);
      check_val("ng2_over", game_over, 0);
      fresh_board("ng2");

      // new_game cancels an in-flight slide; the late ack is ignored
      br = 1'b1;
      tick();
      check_val("cancel_req", sif.slide_req, 1);
      ng = 1'b1;
      tick();
      ng = 1'b0;
      br = 1'b0;
      check_val("cancel_req_drop", sif.slide_req, 0);
      sif.slide_ack    = 1'b1;
      sif.slide_board  = F2;
      sif.slide_points = 13'd7;
      tick();
      sif.slide_ack = 1'b0;
      wait_ready(40, "cancel", cyc);
      fresh_board("cancel");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
